// File: rtl/output_port_arbiter_if.sv
// Request/flit-status inputs and grant/select outputs between one output
// port's arbiter and the router's input ports / crossbar.
interface output_port_arbiter_if #(
  parameter int NPORTS = 5,
  parameter int SELW   = 3
);
  logic [NPORTS-1:0] req_i;
  logic [NPORTS-1:0] valid_i;
  logic [NPORTS-1:0] tail_i;
  logic              out_ready_i;
  logic [NPORTS-1:0] grant_o;
  logic [SELW-1:0]   sel_o;
  logic              busy_o;
  logic              xfer_o;

  modport master (
    output req_i, valid_i, tail_i, out_ready_i,
    input  grant_o, sel_o, busy_o, xfer_o
  );

  modport slave (
    input  req_i, valid_i, tail_i, out_ready_i,
    output grant_o, sel_o, busy_o, xfer_o
  );
endinterface

// File: rtl/output_port_arbiter.sv
// Wormhole-locking round-robin arbiter for one mesh-router output port:
// grants one input for a whole packet, releases on its tail transfer.
module output_port_arbiter #(
  parameter int NPORTS = 5,
  parameter int SELW   = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output_port_arbiter_if.slave   bus
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [NPORTS-1:0] grant_q, grant_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [SELW-1:0]   win_sel;
  logic              win_found;
  logic              xfer;
  int                idx;

  // Rotating-priority scan starting at ptr_q; first requester wins.
  always_comb begin
    win_found = 1'b0;
    win_sel   = '0;
    idx       = 0;
    for (int i = 0; i < NPORTS; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!win_found && bus.req_i[SELW'(idx)]) begin
        win_found = 1'b1;
        win_sel   = SELW'(idx);
      end
    end
  end

  assign xfer = (state_q == LOCKED) & bus.valid_i[sel_q] & bus.out_ready_i;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCKED;
          grant_d = {{(NPORTS-1){1'b0}}, 1'b1} << win_sel;
          sel_d   = win_sel;
        end
      end
      LOCKED: begin
        // Only the owner's tail transfer ends the packet; everything else is ignored.
        if (xfer && bus.tail_i[sel_q]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (sel_q == SELW'(NPORTS - 1)) ? '0 : sel_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.grant_o = grant_q;
  assign bus.sel_o   = sel_q;
  assign bus.busy_o  = (state_q == LOCKED);
  assign bus.xfer_o  = xfer;

endmodule

// File: tb/tb_output_port_arbiter.sv
// Self-checking bench for output_port_arbiter: directed table, corner sequences,
// and randomized traffic against a packet-level round-robin reference.
module tb_output_port_arbiter;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  output_port_arbiter_if #(.NPORTS(N), .SELW(3)) bus ();

  output_port_arbiter #(.NPORTS(N), .SELW(3)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic       rst_v;
    logic [4:0] req, valid, tail;
    logic       rdy;
    logic [4:0] grant;
    logic [2:0] sel;
    logic       busy, xfer;
  } vec_t;

  vec_t tbl[16];
  int n_vec = 0;
  int n_err = 0;

  // Reference: packet-level view (who owns the port, where priority starts).
  bit  m_busy;
  int  m_owner, m_sel, m_ptr;
  int  waits[N];

  logic [4:0] s_grant;
  logic [2:0] s_sel;
  logic       s_busy, s_xfer;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_sel = 0; m_ptr = 0;
    for (int k = 0; k < N; k++) waits[k] = 0;
  endtask

  task automatic model_step(input logic [4:0] req, valid, tail, input logic rdy);
    int worst;
    if (!m_busy) begin
      if (req != 0) begin
        for (int i = 0; i < N; i++) begin
          if (!m_busy && req[(m_ptr + i) % N]) begin
            m_busy  = 1;
            m_owner = (m_ptr + i) % N;
            m_sel   = m_owner;
          end
        end
        worst = 0;
        for (int k = 0; k < N; k++) begin
          if (k == m_owner) waits[k] = 0;
          else if (req[k])  waits[k]++;
          else              waits[k] = 0;
          if (waits[k] > worst) worst = waits[k];
        end
        chk("fairness_wait_le_4", (worst <= N - 1), 1);
      end
    end else if (valid[m_owner] && rdy && tail[m_owner]) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % N;
    end
  endtask

  // One clock: drive after the edge, sample on the falling edge, advance model.
  task automatic cyc(input logic rst_v, input logic [4:0] req, valid, tail, input logic rdy,
                     input bit use_tbl, input vec_t v);
    logic [4:0] eg;
    logic [2:0] es;
    logic       eb, ex;
    rst_n           = rst_v;
    bus.req_i       = req;
    bus.valid_i     = valid;
    bus.tail_i      = tail;
    bus.out_ready_i = rdy;
    if (!rst_v) model_reset();
    @(negedge clk);
    s_grant = bus.grant_o; s_sel = bus.sel_o; s_busy = bus.busy_o; s_xfer = bus.xfer_o;
    if (use_tbl) begin
      eg = v.grant; es = v.sel; eb = v.busy; ex = v.xfer;
    end else begin
      eg = m_busy ? (5'b00001 << m_owner) : 5'b00000;
      es = 3'(m_sel);
      eb = m_busy;
      ex = m_busy && valid[m_owner] && rdy;
    end
    chk("grant_o", s_grant, eg);
    chk("sel_o",   s_sel,   es);
    chk("busy_o",  s_busy,  eb);
    chk("xfer_o",  s_xfer,  ex);
    chk("inv_onehot0",  $onehot0(s_grant), 1);
    chk("inv_busy_or",  s_busy, |s_grant);
    if (s_sel < N) chk("inv_grant_sel", s_grant[s_sel], s_busy);
    if (rst_v) model_step(req, valid, tail, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic rst_v, input logic [4:0] req, valid, tail, input logic rdy);
    vec_t dummy;
    dummy = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0, 1'b0};
    cyc(rst_v, req, valid, tail, rdy, 1'b0, dummy);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_i = '0; bus.valid_i = '0; bus.tail_i = '0; bus.out_ready_i = 1'b0;
    model_reset();

    // rst, req, valid, tail, rdy  ->  grant, sel, busy, xfer
    tbl[0]  = '{0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 3'd0, 0, 0};
    tbl[1]  = '{1, 5'b00100, 5'b00000, 5'b00000, 0, 5'b00000, 3'd0, 0, 0};
    tbl[2]  = '{1, 5'b00000, 5'b00100, 5'b00000, 1, 5'b00100, 3'd2, 1, 1};
    tbl[3]  = '{1, 5'b00000, 5'b00100, 5'b00000, 1, 5'b00100, 3'd2, 1, 1};
    tbl[4]  = '{1, 5'b00000, 5'b00100, 5'b00100, 1, 5'b00100, 3'd2, 1, 1};
    tbl[5]  = '{1, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 3'd2, 0, 0};
    tbl[6]  = '{0, 5'b10011, 5'b11111, 5'b11111, 1, 5'b00000, 3'd0, 0, 0};
    tbl[7]  = '{1, 5'b10011, 5'b11111, 5'b11111, 1, 5'b00000, 3'd0, 0, 0};
    tbl[8]  = '{1, 5'b10011, 5'b11111, 5'b11111, 1, 5'b00001, 3'd0, 1, 1};
    tbl[9]  = '{1, 5'b10011, 5'b11111, 5'b11111, 1, 5'b00000, 3'd0, 0, 0};
    tbl[10] = '{1, 5'b10011, 5'b11111, 5'b11111, 1, 5'b00010, 3'd1, 1, 1};
    tbl[11] = '{1, 5'b10011, 5'b11111, 5'b11111, 1, 5'b00000, 3'd1, 0, 0};
    tbl[12] = '{1, 5'b10011, 5'b11111, 5'b11111, 1, 5'b10000, 3'd4, 1, 1};
    tbl[13] = '{1, 5'b10011, 5'b11111, 5'b11111, 1, 5'b00000, 3'd4, 0, 0};
    tbl[14] = '{1, 5'b10011, 5'b11111, 5'b11111, 1, 5'b00001, 3'd0, 1, 1};
    tbl[15] = '{1, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 3'd0, 0, 0};

    #2;
    foreach (tbl[i])
      cyc(tbl[i].rst_v, tbl[i].req, tbl[i].valid, tbl[i].tail, tbl[i].rdy, 1'b1, tbl[i]);

    // Backpressure on a single-flit packet from port 1 (ptr is now 1).
    run(1, 5'b00010, 5'b00000, 5'b00000, 0);
    for (int i = 0; i < 10; i++) begin
      run(1, 5'b00010, 5'b00010, 5'b00010, 0);
      chk("bp_grant_held", s_grant, 5'b00010);
      chk("bp_no_xfer", s_xfer, 1'b0);
    end
    run(1, 5'b00010, 5'b00010, 5'b00010, 1);
    chk("bp_xfer_once", s_xfer, 1'b1);
    run(1, 5'b00000, 5'b00000, 5'b00000, 0);
    chk("bp_released", s_grant, 5'b00000);

    // Lock on port 3 ignores req changes and a foreign tail.
    run(1, 5'b01000, 5'b00000, 5'b00000, 0);
    for (int i = 0; i < 3; i++) begin
      run(1, 5'b00001, 5'b01001, 5'b00001, 1);
      chk("lock3_grant", s_grant, 5'b01000);
    end
    run(1, 5'b00001, 5'b01001, 5'b01001, 1);
    chk("lock3_tail_xfer", s_xfer, 1'b1);
    run(1, 5'b00000, 5'b00000, 5'b00000, 0);
    chk("lock3_released", s_busy, 1'b0);

    // Asynchronous reset in the middle of a port-4 packet.
    run(1, 5'b10000, 5'b00000, 5'b00000, 0);
    run(1, 5'b00000, 5'b10000, 5'b00000, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_grant", bus.grant_o, 5'b00000);
    chk("async_rst_busy",  bus.busy_o, 1'b0);
    model_reset();
    #1 rst_n = 1'b1;
    run(1, 5'b11111, 5'b00000, 5'b00000, 0);
    run(1, 5'b11111, 5'b00000, 5'b00000, 0);
    chk("post_rst_grant_port0", s_grant, 5'b00001);

    // Randomized traffic.
    run(0, 5'b00000, 5'b00000, 5'b00000, 0);
    for (int i = 0; i < 10000; i++)
      run(1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
          5'($urandom & $urandom), ($urandom_range(0, 3) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
